// File: rtl/tlb_pkg.sv
// ---------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the fully-associative TLB tag array.
//   - Default parameter widths.
//   - Header field layout: {asid, g, vpn2, mask}, mask at bit 0.
//   - mask_to_oddsel(): one-hot selector of the vaddr bit that picks the
//     odd page of an even/odd pair for a given PageMask.
// ---------------------------------------------------------------------------
package tlb_pkg;

    localparam int DEF_ENTRIES = 16;
    localparam int DEF_ASID_W  = 8;
    localparam int DEF_MASK_W  = 16;
    localparam int DEF_VPN2_W  = 19;

    // Header field offsets within one stored header word.
    function automatic int hdr_mask_off();
        return 0;
    endfunction

    function automatic int hdr_vpn2_off(input int mask_w);
        return mask_w;
    endfunction

    function automatic int hdr_g_off(input int mask_w, input int vpn2_w);
        return mask_w + vpn2_w;
    endfunction

    function automatic int hdr_asid_off(input int mask_w, input int vpn2_w);
        return mask_w + vpn2_w + 1;
    endfunction

    function automatic int hdr_width(input int mask_w, input int vpn2_w, input int asid_w);
        return mask_w + vpn2_w + 1 + asid_w;
    endfunction

    // evenOddMask = {mask,1} & {1,~mask}. The mask is zero-extended to 32
    // bits; because the bits above MASK_W are zero, bit MASK_W of the result
    // is mask[MASK_W-1] and every bit above it is zero, so the caller can
    // simply keep bits [MASK_W:0].
    function automatic logic [32:0] mask_to_oddsel(input logic [31:0] mask);
        return {mask, 1'b1} & {1'b1, ~mask};
    endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// ---------------------------------------------------------------------------
// tlb_entry_match
// One TLB tag slot: header register + valid bit, with combinational match
// against the fetch port, the data port and the probe request, plus the
// odd-page select for the fetch and data ports.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   we_i, clr_i          write this slot / invalidate (write wins)
//   wr_*_i               header fields to write
//   fetch_vpn2_i/_pg_i   fetch VPN2 and vaddr[12+MASK_W:12]
//   data_vpn2_i/_pg_i    data  VPN2 and vaddr[12+MASK_W:12]
//   asid_i               current ASID for both lookup ports
//   probe_vpn2_i/_asid_i probe key
//   match_f_o/_d_o/_p_o  match on fetch / data / probe
//   odd_f_o/_d_o         odd-page select for fetch / data
// ---------------------------------------------------------------------------
module tlb_entry_match
    import tlb_pkg::*;
#(
    parameter int ASID_W = DEF_ASID_W,
    parameter int MASK_W = DEF_MASK_W,
    parameter int VPN2_W = DEF_VPN2_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [VPN2_W-1:0] wr_vpn2_i,
    input  logic [ASID_W-1:0] wr_asid_i,
    input  logic              wr_g_i,
    input  logic [MASK_W-1:0] wr_mask_i,
    input  logic [VPN2_W-1:0] fetch_vpn2_i,
    input  logic [MASK_W:0]   fetch_pg_i,
    input  logic [VPN2_W-1:0] data_vpn2_i,
    input  logic [MASK_W:0]   data_pg_i,
    input  logic [ASID_W-1:0] asid_i,
    input  logic [VPN2_W-1:0] probe_vpn2_i,
    input  logic [ASID_W-1:0] probe_asid_i,
    output logic              match_f_o,
    output logic              match_d_o,
    output logic              match_p_o,
    output logic              odd_f_o,
    output logic              odd_d_o
);

    localparam int HDR_W    = hdr_width(MASK_W, VPN2_W, ASID_W);
    localparam int MASK_OFF = hdr_mask_off();
    localparam int VPN2_OFF = hdr_vpn2_off(MASK_W);
    localparam int G_OFF    = hdr_g_off(MASK_W, VPN2_W);
    localparam int ASID_OFF = hdr_asid_off(MASK_W, VPN2_W);

    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic              valid_q, valid_d;
    logic [MASK_W-1:0] tag_mask_s;
    logic [VPN2_W-1:0] tag_vpn2_s;
    logic              tag_g_s;
    logic [ASID_W-1:0] tag_asid_s;
    logic [VPN2_W-1:0] cmp_mask_s;
    logic [32:0]       oddsel_full_s;
    logic [MASK_W:0]   oddsel_s;
    logic              unused_oddsel_s;

    // Next-state of the header and valid bit: a write beats a flush.
    always_comb begin
        hdr_d   = hdr_q;
        valid_d = valid_q;
        if (we_i) begin
            hdr_d[MASK_OFF +: MASK_W] = wr_mask_i;
            hdr_d[VPN2_OFF +: VPN2_W] = wr_vpn2_i;
            hdr_d[G_OFF]              = wr_g_i;
            hdr_d[ASID_OFF +: ASID_W] = wr_asid_i;
            valid_d                   = 1'b1;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            hdr_q   <= hdr_d;
            valid_q <= valid_d;
        end
    end

    assign tag_mask_s = hdr_q[MASK_OFF +: MASK_W];
    assign tag_vpn2_s = hdr_q[VPN2_OFF +: VPN2_W];
    assign tag_g_s    = hdr_q[G_OFF];
    assign tag_asid_s = hdr_q[ASID_OFF +: ASID_W];

    // Mask bits mark VPN2 bits that are "don't care"; bits above MASK_W always compare.
    assign cmp_mask_s = ~(VPN2_W'(tag_mask_s));

    assign oddsel_full_s   = mask_to_oddsel(32'(tag_mask_s));
    assign oddsel_s        = oddsel_full_s[MASK_W:0];
    assign unused_oddsel_s = ^oddsel_full_s[32:MASK_W+1];

    assign match_f_o = valid_q & ~(|((fetch_vpn2_i ^ tag_vpn2_s) & cmp_mask_s))
                     & (tag_g_s | (tag_asid_s == asid_i));
    assign match_d_o = valid_q & ~(|((data_vpn2_i ^ tag_vpn2_s) & cmp_mask_s))
                     & (tag_g_s | (tag_asid_s == asid_i));
    assign match_p_o = valid_q & ~(|((probe_vpn2_i ^ tag_vpn2_s) & cmp_mask_s))
                     & (tag_g_s | (tag_asid_s == probe_asid_i));

    assign odd_f_o = |(fetch_pg_i & oddsel_s);
    assign odd_d_o = |(data_pg_i & oddsel_s);

endmodule

// File: rtl/tlb_assoc_array.sv
// ---------------------------------------------------------------------------
// tlb_assoc_array
// Fully-associative TLB tag array with two registered lookup ports (fetch
// and data), TLBWI/TLBWR write path, TLBP probe, flush and the CP0 Random
// counter. Only tags are held; the caller indexes its PFN/flag RAM with
// idx_*/odd_* (lookups) or wr_slot (writes).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   vaddr_i, vaddr_d, asid        lookup inputs (fetch, data, current ASID)
//   hit_*, idx_*, odd_*           registered lookup results
//   multihit                      registered: >1 match on any port/probe
//   wr_idx_en, wr_rnd_en          TLBWI / TLBWR strobes
//   wr_index, wr_vpn2, wr_asid,
//   wr_g, wr_mask                 write data
//   wr_slot                       slot written this cycle (combinational)
//   probe_req, probe_vpn2,
//   probe_asid                    TLBP request
//   probe_done/_miss/_idx         registered probe result
//   wired, wired_we               CP0 Wired value and write strobe
//   random                        CP0 Random
//   flush                         invalidate every entry
// ---------------------------------------------------------------------------
module tlb_assoc_array
    import tlb_pkg::*;
#(
    parameter  int ENTRIES = DEF_ENTRIES,
    parameter  int ASID_W  = DEF_ASID_W,
    parameter  int MASK_W  = DEF_MASK_W,
    parameter  int VPN2_W  = DEF_VPN2_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       vaddr_i,
    input  logic [31:0]       vaddr_d,
    input  logic [ASID_W-1:0] asid,
    output logic              hit_i,
    output logic              hit_d,
    output logic [IDX_W-1:0]  idx_i,
    output logic [IDX_W-1:0]  idx_d,
    output logic              odd_i,
    output logic              odd_d,
    output logic              multihit,
    input  logic              wr_idx_en,
    input  logic              wr_rnd_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [VPN2_W-1:0] wr_vpn2,
    input  logic [ASID_W-1:0] wr_asid,
    input  logic              wr_g,
    input  logic [MASK_W-1:0] wr_mask,
    output logic [IDX_W-1:0]  wr_slot,
    input  logic              probe_req,
    input  logic [VPN2_W-1:0] probe_vpn2,
    input  logic [ASID_W-1:0] probe_asid,
    output logic              probe_done,
    output logic              probe_miss,
    output logic [IDX_W-1:0]  probe_idx,
    input  logic [IDX_W-1:0]  wired,
    input  logic              wired_we,
    output logic [IDX_W-1:0]  random,
    input  logic              flush
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] match_f_s, match_d_s, match_p_s;
    logic [ENTRIES-1:0] odd_f_s, odd_d_s;
    logic [IDX_W:0]     enc_f_s, enc_d_s, enc_p_s;
    logic               multi_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_slot_s;
    logic [IDX_W-1:0]   random_q, random_d;
    logic               hit_i_q, hit_d_q, odd_i_q, odd_d_q, multihit_q;
    logic [IDX_W-1:0]   idx_i_q, idx_d_q, probe_idx_q;
    logic               probe_done_q, probe_miss_q;
    logic               unused_s;

    // Lowest-index match wins; result is {odd, index}, all zero on no match.
    function automatic logic [IDX_W:0] prio_enc(input logic [ENTRIES-1:0] v,
                                                input logic [ENTRIES-1:0] odd);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = {odd[k], IDX_W'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // v & (v-1) clears the lowest set bit; anything left means two or more.
    function automatic logic has_multi(input logic [ENTRIES-1:0] v);
        return |(v & (v - ENTRIES'(1'b1)));
    endfunction

    assign wr_en_s   = wr_idx_en | wr_rnd_en;
    assign wr_slot_s = wr_idx_en ? wr_index : random_q;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        tlb_entry_match #(
            .ASID_W (ASID_W),
            .MASK_W (MASK_W),
            .VPN2_W (VPN2_W)
        ) u_entry (
            .clk          (clk),
            .rst_n        (rst_n),
            .we_i         (wr_en_s && (wr_slot_s == IDX_W'(g))),
            .clr_i        (flush),
            .wr_vpn2_i    (wr_vpn2),
            .wr_asid_i    (wr_asid),
            .wr_g_i       (wr_g),
            .wr_mask_i    (wr_mask),
            .fetch_vpn2_i (vaddr_i[31:32-VPN2_W]),
            .fetch_pg_i   (vaddr_i[12+MASK_W:12]),
            .data_vpn2_i  (vaddr_d[31:32-VPN2_W]),
            .data_pg_i    (vaddr_d[12+MASK_W:12]),
            .asid_i       (asid),
            .probe_vpn2_i (probe_vpn2),
            .probe_asid_i (probe_asid),
            .match_f_o    (match_f_s[g]),
            .match_d_o    (match_d_s[g]),
            .match_p_o    (match_p_s[g]),
            .odd_f_o      (odd_f_s[g]),
            .odd_d_o      (odd_d_s[g])
        );
    end

    assign enc_f_s = prio_enc(match_f_s, odd_f_s);
    assign enc_d_s = prio_enc(match_d_s, odd_d_s);
    assign enc_p_s = prio_enc(match_p_s, '0);
    assign multi_s = has_multi(match_f_s) | has_multi(match_d_s)
                   | (probe_req & has_multi(match_p_s));

    // Page-offset bits and the probe odd bit carry no tag information.
    assign unused_s = ^{vaddr_i[11:0], vaddr_d[11:0], enc_p_s[IDX_W]};

    // Random counter: counts down through [wired, ENTRIES-1]; holds during TLBWR.
    always_comb begin
        random_d = random_q;
        if (wired_we) begin
            random_d = LAST_IDX;
        end else if (wr_rnd_en) begin
            random_d = random_q;
        end else if ((random_q == wired) || (random_q == '0)) begin
            random_d = LAST_IDX;
        end else begin
            random_d = random_q - IDX_W'(1'b1);
        end
    end

    // Registered lookup/probe results and the Random register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_i_q      <= 1'b0;
            hit_d_q      <= 1'b0;
            idx_i_q      <= '0;
            idx_d_q      <= '0;
            odd_i_q      <= 1'b0;
            odd_d_q      <= 1'b0;
            multihit_q   <= 1'b0;
            probe_done_q <= 1'b0;
            probe_miss_q <= 1'b0;
            probe_idx_q  <= '0;
            random_q     <= LAST_IDX;
        end else begin
            hit_i_q      <= |match_f_s;
            hit_d_q      <= |match_d_s;
            idx_i_q      <= enc_f_s[IDX_W-1:0];
            idx_d_q      <= enc_d_s[IDX_W-1:0];
            odd_i_q      <= enc_f_s[IDX_W];
            odd_d_q      <= enc_d_s[IDX_W];
            multihit_q   <= multi_s;
            probe_done_q <= probe_req;
            random_q     <= random_d;
            // Index.P / Index keep their value until the next probe.
            if (probe_req) begin
                probe_miss_q <= ~(|match_p_s);
                probe_idx_q  <= enc_p_s[IDX_W-1:0];
            end else begin
                probe_miss_q <= probe_miss_q;
                probe_idx_q  <= probe_idx_q;
            end
        end
    end

    assign hit_i      = hit_i_q;
    assign hit_d      = hit_d_q;
    assign idx_i      = idx_i_q;
    assign idx_d      = idx_d_q;
    assign odd_i      = odd_i_q;
    assign odd_d      = odd_d_q;
    assign multihit   = multihit_q;
    assign wr_slot    = wr_slot_s;
    assign probe_done = probe_done_q;
    assign probe_miss = probe_miss_q;
    assign probe_idx  = probe_idx_q;
    assign random     = random_q;

endmodule

// File: tb/tb_tlb_assoc_array.sv
// ---------------------------------------------------------------------------
// tb_tlb_assoc_array
// Directed scenarios with literal expectations followed by randomized
// traffic, all compared every cycle against a behavioural TLB model.
// ---------------------------------------------------------------------------
module tb_tlb_assoc_array;

    localparam int E  = 16;
    localparam int AW = 8;
    localparam int MW = 16;
    localparam int VW = 19;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   vaddr_i, vaddr_d;
    logic [AW-1:0] asid;
    logic          hit_i, hit_d, odd_i, odd_d, multihit;
    logic [IW-1:0] idx_i, idx_d;
    logic          wr_idx_en, wr_rnd_en, wr_g;
    logic [IW-1:0] wr_index, wr_slot;
    logic [VW-1:0] wr_vpn2;
    logic [AW-1:0] wr_asid;
    logic [MW-1:0] wr_mask;
    logic          probe_req, probe_done, probe_miss;
    logic [VW-1:0] probe_vpn2;
    logic [AW-1:0] probe_asid;
    logic [IW-1:0] probe_idx, wired, random;
    logic          wired_we, flush;

    always #5 clk = ~clk;

    tlb_assoc_array dut (
        .clk(clk), .rst_n(rst_n), .vaddr_i(vaddr_i), .vaddr_d(vaddr_d), .asid(asid),
        .hit_i(hit_i), .hit_d(hit_d), .idx_i(idx_i), .idx_d(idx_d),
        .odd_i(odd_i), .odd_d(odd_d), .multihit(multihit),
        .wr_idx_en(wr_idx_en), .wr_rnd_en(wr_rnd_en), .wr_index(wr_index),
        .wr_vpn2(wr_vpn2), .wr_asid(wr_asid), .wr_g(wr_g), .wr_mask(wr_mask),
        .wr_slot(wr_slot), .probe_req(probe_req), .probe_vpn2(probe_vpn2),
        .probe_asid(probe_asid), .probe_done(probe_done), .probe_miss(probe_miss),
        .probe_idx(probe_idx), .wired(wired), .wired_we(wired_we),
        .random(random), .flush(flush)
    );

    // Behavioural model: a table of entries, masks held as contiguous low ones.
    bit          m_valid[E];
    int unsigned m_vpn2[E], m_asid[E], m_mask[E];
    bit          m_g[E];
    int unsigned m_random;

    int unsigned e_hit_i, e_idx_i, e_odd_i, e_hit_d, e_idx_d, e_odd_d;
    int unsigned e_multi, e_pdone, e_pmiss, e_pidx;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Page of 4KB*(mask+1) pairs: VPN2 bits below popcount(mask) are ignored,
    // the odd page is vaddr bit 12+popcount(mask).
    task automatic find(input int unsigned vpn2, input int unsigned as_v,
                        input logic [31:0] va, output int unsigned hit,
                        output int unsigned idx, output int cnt, output int unsigned odd);
        int n;
        hit = 0; idx = 0; cnt = 0; odd = 0;
        for (int k = 0; k < E; k++) begin
            if (m_valid[k]) begin
                n = $countones(m_mask[k]);
                if (((vpn2 >> n) == (m_vpn2[k] >> n)) && (m_g[k] || (m_asid[k] == as_v))) begin
                    cnt++;
                    if (hit == 0) begin
                        hit = 1;
                        idx = k;
                        odd = va[12 + n];
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        int unsigned ph, pi, dummy;
        int cf, cd, cp;
        int unsigned slot;
        if (!rst_n) begin
            for (int k = 0; k < E; k++) begin
                m_valid[k] = 0; m_vpn2[k] = 0; m_asid[k] = 0; m_mask[k] = 0; m_g[k] = 0;
            end
            m_random = E - 1;
            e_hit_i = 0; e_idx_i = 0; e_odd_i = 0; e_hit_d = 0; e_idx_d = 0; e_odd_d = 0;
            e_multi = 0; e_pdone = 0; e_pmiss = 0; e_pidx = 0;
        end else begin
            find(vaddr_i >> 13, asid, vaddr_i, e_hit_i, e_idx_i, cf, e_odd_i);
            find(vaddr_d >> 13, asid, vaddr_d, e_hit_d, e_idx_d, cd, e_odd_d);
            find(probe_vpn2, probe_asid, 32'h0, ph, pi, cp, dummy);
            e_multi = ((cf > 1) || (cd > 1) || (probe_req && (cp > 1))) ? 1 : 0;
            e_pdone = probe_req;
            if (probe_req) begin
                e_pmiss = (ph == 0) ? 1 : 0;
                e_pidx  = pi;
            end
            slot = wr_idx_en ? wr_index : m_random;
            if (flush) begin
                for (int k = 0; k < E; k++) m_valid[k] = 0;
            end
            if (wr_idx_en || wr_rnd_en) begin
                m_valid[slot] = 1; m_vpn2[slot] = wr_vpn2; m_asid[slot] = wr_asid;
                m_g[slot] = wr_g; m_mask[slot] = wr_mask;
            end
            if (wired_we) m_random = E - 1;
            else if (wr_rnd_en) m_random = m_random;
            else if ((m_random == wired) || (m_random == 0)) m_random = E - 1;
            else m_random = m_random - 1;
        end
    endtask

    // One clock: inputs already applied after the falling edge.
    task automatic cycle();
        if (wr_idx_en || wr_rnd_en) begin
            #1;
            chk("wr_slot", wr_slot, wr_idx_en ? wr_index : m_random);
        end
        @(posedge clk);
        model_step();
        #1;
        chk("hit_i", hit_i, e_hit_i);
        chk("idx_i", idx_i, e_idx_i);
        chk("odd_i", odd_i, e_odd_i);
        chk("hit_d", hit_d, e_hit_d);
        chk("idx_d", idx_d, e_idx_d);
        chk("odd_d", odd_d, e_odd_d);
        chk("multihit", multihit, e_multi);
        chk("probe_done", probe_done, e_pdone);
        if (e_pdone != 0) begin
            chk("probe_miss", probe_miss, e_pmiss);
            chk("probe_idx", probe_idx, e_pidx);
        end
        chk("random", random, m_random);
        @(negedge clk);
    endtask

    task automatic tlbwi(input int unsigned idx, input int unsigned vpn2,
                         input int unsigned as_v, input bit g, input int unsigned mask);
        wr_idx_en = 1'b1; wr_index = IW'(idx); wr_vpn2 = VW'(vpn2);
        wr_asid = AW'(as_v); wr_g = g; wr_mask = MW'(mask);
        cycle();
        wr_idx_en = 1'b0;
    endtask

    int unsigned masks[3] = '{0, 3, 15};
    int unsigned r;

    initial begin
        rst_n = 1'b0; vaddr_i = '0; vaddr_d = '0; asid = '0;
        wr_idx_en = 1'b0; wr_rnd_en = 1'b0; wr_index = '0; wr_vpn2 = '0;
        wr_asid = '0; wr_g = 1'b0; wr_mask = '0; probe_req = 1'b0;
        probe_vpn2 = '0; probe_asid = '0; wired = '0; wired_we = 1'b0; flush = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_random", random, 32'd15);
        chk("reset_hit_d", hit_d, 32'd0);

        // Empty array: no hit.
        rst_n = 1'b1; vaddr_d = 32'h0040_0000;
        cycle();
        chk("empty_hit_d", hit_d, 32'd0);
        chk("empty_multihit", multihit, 32'd0);

        // TLBWI slot 3, 4KB pair, ASID-private.
        tlbwi(3, 32'h200, 5, 1'b0, 0);
        vaddr_d = 32'h0040_1000; asid = 8'd5;
        cycle();
        chk("wi_hit_d", hit_d, 32'd1);
        chk("wi_idx_d", idx_d, 32'd3);
        chk("wi_odd_d", odd_d, 32'd1);
        asid = 8'd6;
        cycle();
        chk("asid_miss_hit_d", hit_d, 32'd0);

        // Global 16KB pair in slot 7.
        tlbwi(7, 32'h200, 0, 1'b1, 32'h3);
        vaddr_i = 32'h0040_6000; asid = 8'd9;
        cycle();
        chk("g16k_hit_i", hit_i, 32'd1);
        chk("g16k_idx_i", idx_i, 32'd7);
        chk("g16k_odd_i", odd_i, 32'd1);
        vaddr_i = 32'h0040_2000;
        cycle();
        chk("g16k_even_hit_i", hit_i, 32'd1);
        chk("g16k_even_odd_i", odd_i, 32'd0);

        // Random counter with Wired=4, TLBWR at Random=9.
        wired = 4'd4; wired_we = 1'b1;
        cycle();
        wired_we = 1'b0;
        chk("wired_we_random", random, 32'd15);
        for (int v = 14; v >= 9; v--) begin
            cycle();
            chk("rnd_seq", random, v);
        end
        wr_rnd_en = 1'b1; wr_vpn2 = 19'h300; wr_asid = 8'd0; wr_g = 1'b1; wr_mask = '0;
        #1;
        chk("tlbwr_slot", wr_slot, 32'd9);
        cycle();
        wr_rnd_en = 1'b0;
        chk("tlbwr_hold", random, 32'd9);
        for (int v = 8; v >= 4; v--) begin
            cycle();
            chk("rnd_seq2", random, v);
        end
        cycle();
        chk("rnd_wrap", random, 32'd15);

        // Duplicate tags, probe, flush.
        tlbwi(2, 32'h100, 1, 1'b0, 0);
        tlbwi(5, 32'h100, 1, 1'b0, 0);
        probe_req = 1'b1; probe_vpn2 = 19'h100; probe_asid = 8'd1;
        cycle();
        chk("dup_probe_done", probe_done, 32'd1);
        chk("dup_probe_idx", probe_idx, 32'd2);
        chk("dup_probe_miss", probe_miss, 32'd0);
        chk("dup_multihit", multihit, 32'd1);
        probe_req = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0; probe_req = 1'b1;
        cycle();
        chk("flush_probe_miss", probe_miss, 32'd1);
        chk("flush_probe_idx", probe_idx, 32'd0);
        probe_req = 1'b0;
        cycle();
        chk("probe_done_pulse", probe_done, 32'd0);

        // Write and lookup of the same address in one cycle.
        vaddr_d = 32'h000A_0000; asid = 8'd2;
        tlbwi(1, 32'h050, 2, 1'b0, 0);
        chk("same_cycle_hit_d", hit_d, 32'd0);
        cycle();
        chk("next_cycle_hit_d", hit_d, 32'd1);
        chk("next_cycle_idx_d", idx_d, 32'd1);

        // Reset during a probe.
        probe_req = 1'b1; probe_vpn2 = 19'h050; probe_asid = 8'd2; rst_n = 1'b0;
        cycle();
        chk("rst_probe_done", probe_done, 32'd0);
        rst_n = 1'b1; probe_req = 1'b0;
        cycle();
        chk("rst_cleared_hit_d", hit_d, 32'd0);

        // Randomized traffic over a small tag space to provoke hits and multihits.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            wr_idx_en  = ($urandom_range(0, 7) == 0);
            wr_rnd_en  = ($urandom_range(0, 7) == 0);
            wr_index   = IW'($urandom_range(0, E - 1));
            wr_vpn2    = VW'($urandom_range(0, 15));
            wr_asid    = AW'($urandom_range(0, 3));
            wr_g       = ($urandom_range(0, 3) == 0);
            r          = $urandom_range(0, 2);
            wr_mask    = MW'(masks[r]);
            flush      = ($urandom_range(0, 39) == 0);
            probe_req  = ($urandom_range(0, 2) == 0);
            probe_vpn2 = VW'($urandom_range(0, 15));
            probe_asid = AW'($urandom_range(0, 3));
            wired_we   = ($urandom_range(0, 19) == 0);
            if (wired_we) wired = IW'($urandom_range(0, E - 1));
            asid       = AW'($urandom_range(0, 3));
            vaddr_i    = (32'($urandom_range(0, 15)) << 13) | 32'($urandom_range(0, 8191));
            vaddr_d    = (32'($urandom_range(0, 15)) << 13) | 32'($urandom_range(0, 8191));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_assoc_array.md
Name: tlb_assoc_array

Overview:
- Fully-associative, parametrised TLB tag array: ENTRIES header slots plus valid bits, random-replacement counter and probe engine.
- Serves the instruction-fetch and data-access lookup ports with registered hit/index/odd results.
- Executes TLBWI/TLBWR/TLBP/flush requests from CP0.
- Holds tags only; the caller indexes the PFN/flag RAM with the returned index and odd bit.

Parameters:
- ENTRIES, 16, number of TLB entries; power of two, 4..64.
- ASID_W, 8, ASID width.
- MASK_W, 16, PageMask width; covers VPN2 bits [MASK_W-1:0].
- VPN2_W, 19, VPN2 width = vaddr[31:13].
- IDX_W, $clog2(ENTRIES), index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- vaddr_i  in  32  fetch virtual address.
- vaddr_d  in  32  data virtual address.
- asid  in  ASID_W  current EntryHi.ASID.
- hit_i, hit_d  out  1  registered hit per port.
- idx_i, idx_d  out  IDX_W  registered matching index.
- odd_i, odd_d  out  1  registered odd-page select.
- multihit  out  1  registered: more than one entry matched on either port or probe.
- wr_idx_en  in  1  TLBWI strobe.
- wr_rnd_en  in  1  TLBWR strobe.
- wr_index  in  IDX_W  CP0 Index.
- wr_vpn2  in  VPN2_W  EntryHi.VPN2.
- wr_asid  in  ASID_W  EntryHi.ASID.
- wr_g  in  1  EntryLo0.G & EntryLo1.G.
- wr_mask  in  MASK_W  PageMask.
- wr_slot  out  IDX_W  index actually written this cycle (for the data RAM).
- probe_req  in  1  TLBP strobe.
- probe_vpn2  in  VPN2_W  EntryHi.VPN2.
- probe_asid  in  ASID_W  EntryHi.ASID.
- probe_done  out  1  one-cycle pulse.
- probe_miss  out  1  Index.P.
- probe_idx  out  IDX_W  matching index.
- wired  in  IDX_W  CP0 Wired.
- wired_we  in  1  Wired written this cycle.
- random  out  IDX_W  CP0 Random.
- flush  in  1  invalidate all entries.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All valid bits 0; header contents 0.
  - random = ENTRIES-1.
  - All registered outputs 0: hit_*, idx_*, odd_*, multihit, probe_done, probe_miss, probe_idx.
- Entry match:
  - match = valid & ((vpn2 ^ tag_vpn2) & {(VPN2_W-MASK_W) ones, ~mask}) == 0 & (G | tag_asid == asid).
  - Invalid entries never match.
- Odd bit:
  - evenOddMask = {mask,1} & {1,~mask}.
  - odd = |(vaddr[12+MASK_W:12] & evenOddMask).
  - Odd bit is taken from the lowest-index matching entry.
- Lookup latency:
  - 1 cycle: outputs at edge N+1 reflect vaddr/asid and array contents sampled at edge N.
  - Lowest-index matching entry wins.
  - On no match: hit=0, idx=0, odd=0.
- Multiple matches: multihit is 1 for the following cycle; idx still reports the lowest index.
- Writes:
  - wr_idx_en writes slot wr_index; wr_rnd_en writes slot random.
  - The written slot becomes valid at the edge; wr_slot shows the chosen slot combinationally.
  - Both strobes high: wr_idx_en wins.
- Same-cycle write and lookup/probe: the lookup or probe sees pre-write contents; the new entry matches from the next cycle.
- Probe:
  - probe_req at edge N gives probe_done=1 at N+1 for one cycle, with probe_miss/probe_idx.
  - On miss: probe_miss=1, probe_idx=0.
  - probe_req held high re-probes every cycle.
- Random counter:
  - Decrements every cycle, except in a cycle where wr_rnd_en is set, where it holds so the written slot is stable.
  - When random==wired, or random==0, the next value is ENTRIES-1.
  - wired_we forces random = ENTRIES-1.
  - wired >= ENTRIES-1 pins random at ENTRIES-1.
- Flush:
  - Clears all valid bits at the edge.
  - Flush and write in the same cycle: the written entry ends up valid (write wins for its slot).
- rst_n has priority over every strobe; a probe in flight when reset asserts produces no probe_done.

Decomposition:
- Package tlb_pkg holds:
  - Header field layout: offsets of mask, vpn2, G and asid in a (MASK_W+VPN2_W+1+ASID_W)-bit header.
  - Default widths.
  - Function mask_to_oddsel(mask).
- One sub-module, tlb_entry_match: a single header register with valid bit, write/clear, and three combinational match outputs plus odd for the I and D ports.
- The top instantiates ENTRIES copies and adds priority encoders, the random counter, the probe register and the output registers.

Test Plan:
- Reset, then lookup vaddr_d=0x0040_0000 → next cycle hit_d=0, multihit=0; random=15.
- TLBWI index 3, vpn2=0x00200, asid=5, G=0, mask=0; lookup vaddr_d=0x0040_1000, asid=5 → hit_d=1, idx_d=3, odd_d=1; same address with asid=6 → hit_d=0.
- Write index 7 with mask=0x0003 (16 KB pages), G=1; lookup vaddr_i=0x0040_6000 with any asid → hit_i=1, idx_i=7, odd_i=1; vaddr_i=0x0040_2000 → odd_i=0.
- wired=4 with wired_we, run 20 cycles → random sequence 15,14,…,4,15,14…; TLBWR in the cycle random=9 → wr_slot=9, random holds 9 that cycle.
- Duplicate tag written at indices 2 and 5; probe → probe_done pulse, probe_idx=2, multihit=1; flush then probe → probe_miss=1.
- TLBWI and lookup of the same address in the same cycle → lookup reports miss, the next cycle's lookup hits; assert rst_n=0 mid-probe → no probe_done, all entries invalid.
